// File: rtl/alu_issue.sv
// Execute-issue register in front of the combinational ALU: valid/ready intake,
// operand select with write-back forwarding, x0 zeroing and shift-amount masking.
module alu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_asel,
  input  logic            in_bsel,
  input  logic [3:0]      in_alusel,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic [3:0]      alusel,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);

  // ALU op encoding shared with the ALU (const.h).
  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_SLL  = 4'd2;
  localparam logic [3:0] SEL_SLT  = 4'd3;
  localparam logic [3:0] SEL_SLTU = 4'd4;
  localparam logic [3:0] SEL_XOR  = 4'd5;
  localparam logic [3:0] SEL_SRL  = 4'd6;
  localparam logic [3:0] SEL_SRA  = 4'd7;
  localparam logic [3:0] SEL_OR   = 4'd8;
  localparam logic [3:0] SEL_AND  = 4'd9;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer keeps its payload stable while valid is high and ready low,
  // and ready never depends combinationally on the same-side valid.

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);
  endfunction

  function automatic logic [XLEN-1:0] shamt_mask(input logic [3:0] sel,
                                                 input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    if (is_shift(sel)) r = {{(XLEN-6){1'b0}}, v[5:0]};
    return r;
  endfunction

  function automatic logic fwd_hit(input logic [4:0] idx);
    return fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == idx);
  endfunction

  function automatic logic [XLEN-1:0] resolve(input logic [4:0] idx,
                                              input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] r;
    if (idx == 5'd0)       r = '0;
    else if (fwd_hit(idx)) r = fwd_data;
    else                   r = rf_val;
    return r;
  endfunction

  // Source description of the held instruction, needed for snooping.
  logic            asel_q;
  logic            bsel_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;

  logic            accept;
  logic            load;
  logic            hold;
  logic            snoop_x;
  logic            snoop_y;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] x_load;
  logic [XLEN-1:0] y_load;
  logic            valid_next;

  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    load     = accept && !flush;
    hold     = out_valid && !out_ready && !flush;

    src1   = resolve(in_rs1, in_rs1_val);
    src2   = resolve(in_rs2, in_rs2_val);
    x_load = in_asel ? in_pc : src1;
    y_load = shamt_mask(in_alusel, in_bsel ? in_imm : src2);

    snoop_x = hold && !asel_q && fwd_hit(rs1_q);
    snoop_y = hold && !bsel_q && fwd_hit(rs2_q);

    // Flush wins over everything; a held instruction stays live.
    valid_next = 1'b0;
    if (flush)     valid_next = 1'b0;
    else if (load) valid_next = 1'b1;
    else if (hold) valid_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      alusel    <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      out_valid <= valid_next;
      if (load) begin
        x         <= x_load;
        y         <= y_load;
        alusel    <= in_alusel;
        out_rd    <= in_rd;
        out_rd_we <= in_rd_we;
        asel_q    <= in_asel;
        bsel_q    <= in_bsel;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
      end else begin
        // A stalled instruction picks up late write-backs it would otherwise miss.
        if (snoop_x) x <= fwd_data;
        if (snoop_y) y <= shamt_mask(alusel, fwd_data);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vectors with literal expectations, plus a
// transaction-level model of the held instruction checked every cycle.
module tb_alu_issue;
  localparam int XLEN = 64;
  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SLL = 4'd2;
  localparam logic [3:0] SEL_XOR = 4'd5;
  localparam logic [3:0] SEL_SRL = 4'd6;
  localparam logic [3:0] SEL_SRA = 4'd7;
  localparam logic [3:0] SEL_OR  = 4'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            flush, in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd, fwd_rd, out_rd;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm, in_pc, fwd_data, x, y;
  logic            in_asel, in_bsel, in_rd_we, fwd_valid, out_valid, out_ready, out_rd_we;
  logic [3:0]      in_alusel, alusel;

  alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_alusel(in_alusel),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .alusel(alusel), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One record describing the instruction the stage currently holds.
  logic            m_valid;
  logic [XLEN-1:0] m_x, m_y;
  logic [3:0]      m_sel;
  logic [4:0]      m_rd, m_rs1, m_rs2;
  logic            m_we, m_x_from_reg, m_y_from_reg;
  logic [XLEN-1:0] exp_q[$];

  function automatic logic shift_op(input logic [3:0] s);
    return s == SEL_SLL || s == SEL_SRL || s == SEL_SRA;
  endfunction

  function automatic logic [XLEN-1:0] operand_of(input logic [4:0] r,
                                                 input logic [XLEN-1:0] rf);
    if (r == 0) return '0;
    if (fwd_valid && fwd_rd == r) return fwd_data;
    return rf;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_x = '0; m_y = '0; m_sel = '0; m_rd = '0; m_we = 1'b0;
      m_rs1 = '0; m_rs2 = '0; m_x_from_reg = 1'b1; m_y_from_reg = 1'b1;
    end else begin
      // Scoreboard: every instruction handed downstream must carry the model's x.
      if (m_valid && out_ready) exp_q.push_back(m_x);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("handoff_unexpected", {63'd0, out_valid}, '0);
        else check("handoff_x", x, exp_q.pop_front());
      end
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_x = in_asel ? in_pc : operand_of(in_rs1, in_rs1_val);
        m_y = in_bsel ? in_imm : operand_of(in_rs2, in_rs2_val);
        if (shift_op(in_alusel)) m_y = m_y % 64;
        m_sel = in_alusel; m_rd = in_rd; m_we = in_rd_we;
        m_rs1 = in_rs1; m_rs2 = in_rs2;
        m_x_from_reg = !in_asel; m_y_from_reg = !in_bsel;
      end else if (m_valid && !out_ready) begin
        if (m_x_from_reg && fwd_valid && fwd_rd != 0 && fwd_rd == m_rs1) m_x = fwd_data;
        if (m_y_from_reg && fwd_valid && fwd_rd != 0 && fwd_rd == m_rs2)
          m_y = shift_op(m_sel) ? fwd_data % 64 : fwd_data;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    if (m_valid) begin
      check("x", x, m_x);
      check("y", y, m_y);
      check("alusel", {60'd0, alusel}, {60'd0, m_sel});
      check("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
      check("out_rd_we", {63'd0, out_rd_we}, {63'd0, m_we});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  task automatic put(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                     input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                     input logic asel, input logic bsel, input logic [3:0] sel,
                     input logic [4:0] rd);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1; in_rs2_val = v2;
    in_imm = imm; in_pc = pc; in_asel = asel; in_bsel = bsel;
    in_alusel = sel; in_rd = rd; in_rd_we = 1;
  endtask

  task automatic fwd(input logic [4:0] rd, input logic [XLEN-1:0] data);
    fwd_valid = 1; fwd_rd = rd; fwd_data = data;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    flush = $urandom_range(0, 1); in_valid = $urandom_range(0, 1);
    out_ready = $urandom_range(0, 1);
    in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
    in_rs1_val = {$urandom, $urandom}; in_rs2_val = {$urandom, $urandom};
    in_imm = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
    in_asel = $urandom_range(0, 1); in_bsel = $urandom_range(0, 1);
    in_alusel = 4'($urandom); in_rd_we = $urandom_range(0, 1);
    fwd_valid = $urandom_range(0, 1); fwd_rd = 5'($urandom);
    fwd_data = {$urandom, $urandom};
    repeat (3) cyc();
    // 1. reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_x", x, 64'd0);
    check("rst_y", y, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    idle(); out_ready = 1;
    rst = 0;
    cyc();

    // 2. ADD with register operands
    put(5'd3, 5'd4, 64'd5, 64'd7, 64'd0, 64'h100, 0, 0, SEL_ADD, 5'd1);
    cyc();
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_x", x, 64'd5);
    check("add_y", y, 64'd7);

    // 3. forwarding on rs1, x0 on rs2
    put(5'd3, 5'd0, 64'h11, 64'hFF, 64'd0, 64'h104, 0, 0, SEL_XOR, 5'd2);
    fwd(5'd3, 64'h99);
    cyc();
    check("fwd_x", x, 64'h99);
    check("x0_y", y, 64'd0);

    // 4. shift amount masking on the immediate, pc as x
    idle();
    put(5'd1, 5'd2, 64'd0, 64'd0, 64'h1C5, 64'h1000, 1, 1, SEL_SLL, 5'd3);
    cyc();
    check("sll_y", y, 64'h05);
    check("sll_x_pc", x, 64'h1000);
    check("sll_sel", {60'd0, alusel}, {60'd0, SEL_SLL});

    // 5. stall with write-back snoop
    put(5'd5, 5'd6, 64'd1, 64'd2, 64'd0, 64'h108, 0, 0, SEL_ADD, 5'd4);
    cyc();
    out_ready = 0;
    put(5'd9, 5'd9, 64'hAA, 64'hBB, 64'd0, 64'h10C, 0, 0, SEL_OR, 5'd7);
    fwd(5'd6, 64'h42);
    cyc();
    check("snoop_y", y, 64'h42);
    check("snoop_x_kept", x, 64'd1);
    check("snoop_sel_kept", {60'd0, alusel}, {60'd0, SEL_ADD});
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    fwd(5'd5, 64'h77);
    cyc();
    check("snoop_x", x, 64'h77);
    fwd(5'd0, 64'h55);
    cyc();
    check("fwd_rd0_ignored_x", x, 64'h77);

    // shift op held: snooped y is masked too
    out_ready = 1; idle();
    put(5'd8, 5'd7, 64'h20, 64'd3, 64'd0, 64'h110, 0, 0, SEL_SRL, 5'd5);
    cyc();
    out_ready = 0; idle(); fwd(5'd7, 64'hFFF);
    cyc();
    check("snoop_mask_y", y, 64'h3F);

    // 6. flush beats accept, then back-to-back accepts
    out_ready = 1; idle();
    put(5'd1, 5'd2, 64'h1, 64'h2, 64'd0, 64'h114, 0, 0, SEL_ADD, 5'd6);
    flush = 1;
    cyc();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      put(5'd1, 5'd2, 64'(i + 10), 64'(i), 64'd0, 64'h200, 0, 0, SEL_ADD, 5'd1);
      cyc();
      check("b2b_valid", {63'd0, out_valid}, 64'd1);
      check("b2b_x", x, 64'(i + 10));
    end
    idle();
    cyc();
    check("drained_valid", {63'd0, out_valid}, 64'd0);

    // reset mid-transfer drops the instruction
    put(5'd2, 5'd3, 64'h5, 64'h6, 64'd0, 64'h300, 0, 0, SEL_ADD, 5'd2);
    cyc();
    idle(); out_ready = 0;
    rst = 1;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    cyc();
    rst = 0; out_ready = 1;
    cyc();
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // mixed vectors checked by the model
    for (int i = 0; i < 60; i++) begin
      in_valid = $urandom_range(0, 1);
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_rs1_val = {$urandom, $urandom}; in_rs2_val = {$urandom, $urandom};
      in_imm = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
      in_asel = $urandom_range(0, 1); in_bsel = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: in_alusel = SEL_ADD;
        1: in_alusel = SEL_SLL;
        2: in_alusel = SEL_SRA;
        default: in_alusel = SEL_SRL;
      endcase
      in_rd = 5'($urandom_range(0, 31)); in_rd_we = $urandom_range(0, 1);
      fwd_valid = $urandom_range(0, 1); fwd_rd = 5'($urandom_range(0, 7));
      fwd_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    idle(); out_ready = 1;
    repeat (2) cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
